// File: rtl/multicycle_seq.sv
`default_nettype none
// ============================================================================
// multicycle_seq : multicycle instruction sequencer with fetch/data memory
//                  handshakes, acknowledge timeout and a retired counter.
// Revision       : 1.0 - initial release
// ============================================================================
module multicycle_seq #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [1:0]  ir_op,
    input  logic        zero,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic [7:0]  ctrl,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel_br,
    output logic        reg_we,
    output logic [2:0]  state,
    output logic        err,
    output logic [15:0] retired
);

    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] C_OP_RTYPE  = 2'b00;
    localparam logic [1:0] C_OP_LOAD   = 2'b01;
    localparam logic [1:0] C_OP_STORE  = 2'b10;
    localparam logic [1:0] C_OP_BRANCH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] retired_q;
    logic        w_retire;

    // {RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp}
    function automatic logic [7:0] decode_ctrl(input logic [1:0] op);
        logic [7:0] v;
        case (op)
            C_OP_RTYPE:  v = 8'b1100_0001;
            C_OP_LOAD:   v = 8'b0110_1010;
            C_OP_STORE:  v = 8'b0010_0100;
            default:     v = 8'b0001_0000;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = 8'd0;
        w_retire  = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        ctrl      = 8'd0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel_br = 1'b0;
        reg_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // An acknowledge on the final allowed cycle still wins.
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == C_WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                // op_q is being loaded this cycle, so decode the live field.
                op_d    = ir_op;
                ctrl    = decode_ctrl(ir_op);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ctrl = decode_ctrl(op_q);
                case (op_q)
                    C_OP_RTYPE: state_d = S_WB;
                    C_OP_LOAD,
                    C_OP_STORE: state_d = S_MEM;
                    default: begin
                        pc_we     = 1'b1;
                        pc_sel_br = zero;
                        w_retire  = 1'b1;
                        state_d   = run ? S_FETCH : S_IDLE;
                    end
                endcase
            end
            S_MEM: begin
                ctrl     = decode_ctrl(op_q);
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (op_q == C_OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_we    = 1'b1;
                        w_retire = 1'b1;
                        state_d  = run ? S_FETCH : S_IDLE;
                    end
                end else if (wait_q == C_WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                ctrl     = decode_ctrl(op_q);
                reg_we   = 1'b1;
                pc_we    = 1'b1;
                w_retire = 1'b1;
                state_d  = run ? S_FETCH : S_IDLE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            wait_q    <= 8'd0;
            retired_q <= 16'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            if (w_retire) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    assign state   = state_q;
    assign err     = (state_q == S_ERR);
    assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_seq.sv
`default_nettype none
// ============================================================================
// tb_multicycle_seq : scoreboard bench for the multicycle sequencer.
// Revision          : 1.0 - initial release
// ============================================================================
module tb_multicycle_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [1:0]  ir_op = 2'b00;
    logic        zero = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, ir_we, pc_we, pc_sel_br, reg_we, err;
    logic [7:0]  ctrl;
    logic [2:0]  state;
    logic [15:0] retired;

    multicycle_seq #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ir_op(ir_op), .zero(zero),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .ctrl(ctrl), .ir_we(ir_we), .pc_we(pc_we), .pc_sel_br(pc_sel_br),
        .reg_we(reg_we), .state(state), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  ctl;
        logic        irw;
        logic        pcw;
        logic        rgw;
        logic        sel;
        logic [15:0] ret;
    } obs_t;

    obs_t        exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] ret_model = 16'd0;

    // memory responder knobs: wait cycles before ack (<0 = never), stray ack
    int          iwait = 0;
    int          dwait = 0;
    int          icnt = 0;
    int          dcnt = 0;
    logic        stray = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] exp_ctrl(input logic [1:0] op);
        case (op)
            2'b00:   return 8'hC1;
            2'b01:   return 8'h6A;
            2'b10:   return 8'h24;
            default: return 8'h10;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (imem_req) begin
                imem_ack = (iwait >= 0 && icnt >= iwait);
                icnt++;
            end else begin
                imem_ack = stray;
                icnt = 0;
            end
            if (dmem_req) begin
                dmem_ack = (dwait >= 0 && dcnt >= dwait);
                dcnt++;
            end else begin
                dmem_ack = stray;
                dcnt = 0;
            end
        end
    end

    initial begin
        obs_t act, expv;
        string nm;
        forever begin
            @(negedge clk);
            if (err) begin
                check("err_quiet", {26'd0, imem_req, dmem_req, ir_we, pc_we, reg_we, pc_sel_br}, 32'd0);
            end
            if (ir_we || pc_we || reg_we) begin
                act = '{st: state, ctl: ctrl, irw: ir_we, pcw: pc_we, rgw: reg_we,
                        sel: pc_sel_br, ret: retired};
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {1'b0, act}, 32'd0);
                end else begin
                    expv = exp_q.pop_front();
                    nm   = name_q.pop_front();
                    check(nm, {1'b0, act}, {1'b0, expv});
                end
            end
        end
    end

    task automatic run_instr(input logic [1:0] op, input logic z, input int iw,
                             input int dw, input bit drop, output logic [23:0] tr);
        obs_t f, r;
        int   lat, explat;
        bit   done;
        ir_op = op;
        zero  = z;
        iwait = iw;
        dwait = dw;
        f = '{st: 3'd1, ctl: 8'h00, irw: 1'b1, pcw: 1'b0, rgw: 1'b0, sel: 1'b0, ret: ret_model};
        case (op)
            2'b00: begin
                r = '{st: 3'd5, ctl: 8'hC1, irw: 1'b0, pcw: 1'b1, rgw: 1'b1, sel: 1'b0, ret: ret_model};
                explat = 4 + iw;
            end
            2'b01: begin
                r = '{st: 3'd5, ctl: 8'h6A, irw: 1'b0, pcw: 1'b1, rgw: 1'b1, sel: 1'b0, ret: ret_model};
                explat = 5 + iw + dw;
            end
            2'b10: begin
                r = '{st: 3'd4, ctl: 8'h24, irw: 1'b0, pcw: 1'b1, rgw: 1'b0, sel: 1'b0, ret: ret_model};
                explat = 4 + iw + dw;
            end
            default: begin
                r = '{st: 3'd3, ctl: 8'h10, irw: 1'b0, pcw: 1'b1, rgw: 1'b0, sel: z, ret: ret_model};
                explat = 3 + iw;
            end
        endcase
        exp_q.push_back(f);
        name_q.push_back("fetch_strobe");
        exp_q.push_back(r);
        name_q.push_back("retire_strobe");
        ret_model = ret_model + 16'd1;
        lat  = 0;
        tr   = '0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            lat++;
            tr = {tr[20:0], state};
            check("ctrl_hold", {24'd0, ctrl},
                  {24'd0, (state >= 3'd2 && state <= 3'd5) ? exp_ctrl(op) : 8'h00});
            if (drop && state == 3'd4) run = 1'b0;
            if (pc_we) done = 1'b1;
        end
        check("retire_seen", {31'd0, done}, 32'd1);
        check("latency", lat, explat);
    endtask

    initial begin
        logic [23:0] tr;
        int          fcnt;
        repeat (3) @(negedge clk);
        check("reset_state", {12'd0, state, err, retired}, 32'd0);
        check("reset_outputs", {18'd0, ctrl, imem_req, dmem_req, ir_we, pc_we, pc_sel_br, reg_we}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_without_run", {29'd0, state}, 32'd0);

        run = 1'b1;
        run_instr(2'b00, 1'b0, 0, 0, 1'b0, tr);
        check("rtype_trace", {20'd0, tr[11:0]}, 32'h29D);
        run_instr(2'b01, 1'b0, 0, 3, 1'b0, tr);
        check("load_trace", tr, 24'o12344445);
        run_instr(2'b11, 1'b1, 0, 0, 1'b0, tr);
        run_instr(2'b11, 1'b0, 1, 0, 1'b0, tr);
        stray = 1'b1;
        run_instr(2'b01, 1'b0, 3, 2, 1'b0, tr);
        stray = 1'b0;
        run_instr(2'b00, 1'b0, 14, 0, 1'b0, tr);
        run_instr(2'b10, 1'b0, 2, 2, 1'b1, tr);
        @(negedge clk);
        check("idle_after_drop", {21'd0, state, ctrl}, 32'd0);
        check("retired_count", {16'd0, retired}, 32'd7);

        iwait = -1;
        run   = 1'b1;
        fcnt  = 0;
        for (int c = 0; c < 100 && state != 3'd6; c++) begin
            @(negedge clk);
            if (state == 3'd1) fcnt++;
        end
        check("timeout_fetch_cycles", fcnt, 15);
        check("timeout_err", {28'd0, state, err}, {28'd0, 3'd6, 1'b1});
        for (int c = 0; c < 6; c++) begin
            run = ~run;
            @(negedge clk);
            check("err_sticky", {28'd0, state, err}, {28'd0, 3'd6, 1'b1});
        end
        run   = 1'b0;
        rst_n = 1'b0;
        iwait = 0;
        @(negedge clk);
        check("reset_from_err", {12'd0, state, err, retired}, 32'd0);
        rst_n     = 1'b1;
        ret_model = 16'd0;
        @(negedge clk);
        check("idle_after_err_reset", {29'd0, state}, 32'd0);

        force dut.retired_q = 16'hFFFE;
        #1;
        release dut.retired_q;
        ret_model = 16'hFFFE;
        run = 1'b1;
        run_instr(2'b10, 1'b0, 0, 0, 1'b0, tr);
        run_instr(2'b10, 1'b0, 0, 1, 1'b1, tr);
        @(negedge clk);
        check("retired_wrap", {16'd0, retired}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/multicycle_seq.md
MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15, max wait cycles for a memory acknowledge (1..255).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL provide port run  input  1  enables instruction sequencing; low = finish current instruction, then idle.
REQ-005 SHALL provide port ir_op  input  2  opcode field of the fetched instruction word.
REQ-006 SHALL provide port zero  input  1  ALU zero flag, valid in EXEC.
REQ-007 SHALL provide ports imem_req/imem_ack  output/input  1/1  instruction fetch handshake.
REQ-008 SHALL provide ports dmem_req/dmem_ack  output/input  1/1  data memory handshake.
REQ-009 SHALL provide port ctrl  output  8  {RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp}.
REQ-010 SHALL provide ports ir_we, pc_we, pc_sel_br, reg_we  output  1 each  one-cycle strobes.
REQ-011 SHALL provide ports state  output  3,  err  output  1,  retired  output  16.

Function
REQ-012 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6; code 7 SHALL go to ERR.
REQ-013 IDLE: run=1 -> FETCH next cycle; else stay.
REQ-014 FETCH: imem_req=1 continuously; on imem_ack=1 -> ir_we=1 that cycle, go DECODE.
REQ-015 DECODE: latch ir_op into internal op_q; drive ctrl from op_q: 00->11000001, 01->01101010, 10->00100100, 11->00010000; go EXEC.
REQ-016 ctrl SHALL hold the op_q decode from DECODE through end of instruction; ctrl=0 in IDLE, FETCH and ERR.
REQ-017 EXEC: op_q=00 -> WB; 01 or 10 -> MEM; 11 -> pc_we=1, pc_sel_br=zero, instruction retires, go FETCH if run else IDLE.
REQ-018 MEM: dmem_req=1 until dmem_ack; on ack op_q=01 -> WB; op_q=10 -> pc_we=1, retire, FETCH/IDLE per run.
REQ-019 WB: reg_we=1, pc_we=1, retire, FETCH if run else IDLE.
REQ-020 Total latency: R-type 4 cycles, branch 3, store 4, load 5, each plus memory wait cycles.
REQ-021 Wait counter SHALL clear on entry to FETCH/MEM and count cycles with req=1, ack=0; reaching TIMEOUT -> ERR, no strobes issued.
REQ-022 ack arriving on the same cycle the counter reaches TIMEOUT SHALL win (normal progression).
REQ-023 ack while req=0 SHALL be ignored.
REQ-024 ERR: err=1, all strobes and reqs 0, sticky until reset; run ignored.
REQ-025 retired SHALL increment by 1 on each retire cycle, wrapping 0xFFFF->0x0000.
REQ-026 run deasserted mid-instruction SHALL NOT abort it; return to IDLE only at retirement.
REQ-027 pc_we, ir_we, reg_we SHALL each be high exactly one cycle per instruction, never in the same cycle as err=1.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force state=IDLE, op_q=0, wait counter=0, retired=0, err=0, all outputs 0, including mid-instruction or from ERR.
REQ-029 Reset release SHALL require run=1 to leave IDLE; no instruction resumes.

Verification
REQ-030 run=1, ir_op=00, acks immediate -> states 1,2,3,5; ctrl=0xC1; reg_we and pc_we in cycle 4; retired=1.
REQ-031 ir_op=01, dmem_ack after 3 wait cycles -> ctrl=0x6A, MEM held 4 cycles, reg_we in WB; retired=1.
REQ-032 ir_op=11, zero=1 -> pc_we=1 and pc_sel_br=1 in EXEC; zero=0 -> pc_sel_br=0; reg_we never set.
REQ-033 imem_ack held 0 with TIMEOUT=15 -> ERR after 15 req cycles, err=1; run toggling has no effect; rst_n=0 -> IDLE.
REQ-034 Preload retired=0xFFFF via 65535 stores, one more store -> retired=0x0000.
REQ-035 run dropped during MEM of a store -> store completes, pc_we pulses, state IDLE next.
